// File: rtl/bidir_io_filt.sv
// bidir_io_filt: per-pin routed bidirectional I/O with output enable, open-drain
// drive, input synchroniser, programmable glitch filter and sticky edge flags.
// Optional feature macro: BIDIR_IO_EVT_EN builds the rise/fall event flags;
// without it rise_evt/fall_evt are tied low and evt_clr is ignored.
module bidir_io_filt #(
  parameter int IOWidth      = 36,
  parameter int PortNumWidth = 8,
  parameter int SyncStages   = 2,
  parameter int FiltWidth    = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [IOWidth-1:0][PortNumWidth-1:0]   portselnum,
  input  logic [IOWidth-1:0]                     out_ena,
  input  logic [IOWidth-1:0]                     od,
  input  logic [IOWidth-1:0]                     out_data,
  input  logic [FiltWidth-1:0]                   filt_len,
  input  logic [IOWidth-1:0]                     evt_clr,
  inout  wire  [IOWidth-1:0]                     gpioport,
  output logic [IOWidth-1:0]                     data_from_gpio,
  output logic [IOWidth-1:0]                     rise_evt,
  output logic [IOWidth-1:0]                     fall_evt
);

  // Index bits actually needed to address a pin; wider selects are range-checked.
  localparam int IdxW = (IOWidth > 1) ? $clog2(IOWidth) : 1;

  logic [IOWidth-1:0] outsel_s;                  // routed out_data per channel
  logic [IOWidth-1:0] raw_s;                     // routed pin value per channel
  logic [IOWidth-1:0] outmux_r;
  logic [IOWidth-1:0] sync_r [SyncStages];
  logic [IOWidth-1:0] s_s;                       // synchronised pin value
  logic [IOWidth-1:0] filt_r;
  logic [FiltWidth-1:0] cnt_r [IOWidth];
  logic [IOWidth-1:0] accept_s;                  // filter takes the new level this clock
  logic [IOWidth-1:0] drv_en_s;
  logic [IOWidth-1:0] drv_val_s;

  // Route out_data and pins through the port-select index; out-of-range reads 0.
  always_comb begin
    outsel_s = '0;
    raw_s    = '0;
    for (int i = 0; i < IOWidth; i++) begin
      if (int'(portselnum[i]) < IOWidth) begin
        outsel_s[i] = out_data[portselnum[i][IdxW-1:0]];
        raw_s[i]    = gpioport[portselnum[i][IdxW-1:0]];
      end else begin
        outsel_s[i] = 1'b0;
        raw_s[i]    = 1'b0;
      end
    end
  end

  // Output mux register: one clock from out_data to the pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outmux_r <= '0;
    end else begin
      outmux_r <= outsel_s;
    end
  end

  // Pin driver: push-pull drives the level, open-drain only pulls low.
  always_comb begin
    drv_en_s  = out_ena & (~od | outmux_r);
    drv_val_s = ~od & outmux_r;
  end

  for (genvar g = 0; g < IOWidth; g++) begin : g_pad
    assign gpioport[g] = drv_en_s[g] ? drv_val_s[g] : 1'bz;
  end

  // Input synchroniser chain; the last stage feeds the filter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SyncStages; k++) sync_r[k] <= '0;
    end else begin
      sync_r[0] <= raw_s;
      for (int k = 1; k < SyncStages; k++) sync_r[k] <= sync_r[k-1];
    end
  end

  assign s_s = sync_r[SyncStages-1];

  // New level is accepted once it has disagreed for filt_len+1 clocks.
  always_comb begin
    accept_s = '0;
    for (int i = 0; i < IOWidth; i++) begin
      if ((s_s[i] != filt_r[i]) && (cnt_r[i] >= filt_len)) begin
        accept_s[i] = 1'b1;
      end else begin
        accept_s[i] = 1'b0;
      end
    end
  end

  // Glitch filter: count disagreeing clocks; cnt only advances while below filt_len, so it cannot wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_r <= '0;
      for (int i = 0; i < IOWidth; i++) cnt_r[i] <= '0;
    end else begin
      for (int i = 0; i < IOWidth; i++) begin
        if (s_s[i] == filt_r[i]) begin
          cnt_r[i] <= '0;
        end else if (accept_s[i]) begin
          filt_r[i] <= s_s[i];
          cnt_r[i]  <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + {{(FiltWidth-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign data_from_gpio = filt_r;

`ifdef BIDIR_IO_EVT_EN
  logic [IOWidth-1:0] rise_r;
  logic [IOWidth-1:0] fall_r;

  // Sticky edge flags; a new edge wins over a clear in the same clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_r <= '0;
      fall_r <= '0;
    end else begin
      rise_r <= (accept_s & s_s)  | (rise_r & ~evt_clr);
      fall_r <= (accept_s & ~s_s) | (fall_r & ~evt_clr);
    end
  end

  assign rise_evt = rise_r;
  assign fall_evt = fall_r;
`else
  logic unused_evt_s;
  assign unused_evt_s = ^evt_clr;
  assign rise_evt     = '0;
  assign fall_evt     = '0;
`endif

endmodule

// File: tb/tb_bidir_io_filt.sv
// Self-checking bench for bidir_io_filt: directed scenarios with literal
// expectations plus randomized traffic against a behavioural pin/filter model.
module tb_bidir_io_filt;
  localparam int IOW = 36;
  localparam int PW  = 8;
  localparam int SS  = 2;
  localparam int FW  = 4;
`ifdef BIDIR_IO_EVT_EN
  localparam logic EVT = 1'b1;
`else
  localparam logic EVT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [IOW-1:0][PW-1:0] portselnum;
  logic [IOW-1:0] out_ena, od, out_data, evt_clr, drv_en, drv_val;
  logic [FW-1:0]  filt_len;
  wire  [IOW-1:0] gpioport;
  logic [IOW-1:0] data_from_gpio, rise_evt, fall_evt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // External world: bench drivers on pins plus a pull-up on every pin.
  for (genvar g = 0; g < IOW; g++) begin : g_pin
    assign gpioport[g] = drv_en[g] ? drv_val[g] : 1'bz;
    pullup (gpioport[g]);
  end

  bidir_io_filt #(.IOWidth(IOW), .PortNumWidth(PW), .SyncStages(SS), .FiltWidth(FW)) dut (
    .clk(clk), .reset(reset), .portselnum(portselnum), .out_ena(out_ena), .od(od),
    .out_data(out_data), .filt_len(filt_len), .evt_clr(evt_clr), .gpioport(gpioport),
    .data_from_gpio(data_from_gpio), .rise_evt(rise_evt), .fall_evt(fall_evt));

  // ---------------- behavioural model ----------------
  logic [IOW-1:0] m_outmux, m_filt, m_rise, m_fall;
  int             m_run [IOW];   // consecutive clocks synchronised level differs from filtered level
  logic [IOW-1:0] m_hist [$];    // raw samples, oldest first; oldest is what the filter sees

  task automatic model_reset();
    m_outmux = '0; m_filt = '0; m_rise = '0; m_fall = '0;
    for (int i = 0; i < IOW; i++) m_run[i] = 0;
    m_hist.delete();
    for (int k = 0; k < SS; k++) m_hist.push_back('0);
  endtask

  // What each pin must read, from drive rules and the pull-up.
  function automatic logic [IOW-1:0] m_pin();
    logic [IOW-1:0] p;
    for (int j = 0; j < IOW; j++) begin
      if (out_ena[j] && !od[j])      p[j] = m_outmux[j];
      else if (out_ena[j] && od[j])  p[j] = ~m_outmux[j];
      else if (drv_en[j])            p[j] = drv_val[j];
      else                           p[j] = 1'b1;
    end
    return p;
  endfunction

  task automatic model_edge(input logic [IOW-1:0] pin);
    logic [IOW-1:0] s, raw, om;
    s = m_hist[0];
    for (int i = 0; i < IOW; i++) begin
      if (s[i] != m_filt[i]) begin
        m_run[i]++;
        if (m_run[i] > int'(filt_len)) begin
          m_filt[i] = s[i];
          m_run[i]  = 0;
          if (EVT && s[i])  m_rise[i] = 1'b1;
          if (EVT && !s[i]) m_fall[i] = 1'b1;
          if (evt_clr[i] && s[i])  m_fall[i] = 1'b0;
          if (evt_clr[i] && !s[i]) m_rise[i] = 1'b0;
        end else begin
          if (evt_clr[i]) begin m_rise[i] = 1'b0; m_fall[i] = 1'b0; end
        end
      end else begin
        m_run[i] = 0;
        if (evt_clr[i]) begin m_rise[i] = 1'b0; m_fall[i] = 1'b0; end
      end
      raw[i] = (portselnum[i] < IOW) ? pin[portselnum[i]] : 1'b0;
      om[i]  = (portselnum[i] < IOW) ? out_data[portselnum[i]] : 1'b0;
    end
    m_outmux = om;
    void'(m_hist.pop_front());
    m_hist.push_back(raw);
  endtask

  task automatic chk_v(input string nm, input logic [IOW-1:0] act, input logic [IOW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  // One clock: inputs were set just after a negedge. Check pins, clock, check outputs.
  task automatic tick();
    logic [IOW-1:0] pin;
    #1;
    pin = m_pin();
    chk_v("gpioport", gpioport, pin);
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge(pin);
    @(negedge clk);
    chk_v("data_from_gpio", data_from_gpio, m_filt);
    chk_v("rise_evt", rise_evt, m_rise);
    chk_v("fall_evt", fall_evt, m_fall);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  function automatic logic [IOW-1:0] rnd36();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[IOW-1:0];
  endfunction

  initial begin
    logic seen;
    logic [3:0] lens [5];
    lens[0] = 4'd0; lens[1] = 4'd1; lens[2] = 4'd4; lens[3] = 4'd15; lens[4] = 4'd2;

    reset = 1'b1; out_ena = '0; od = '0; out_data = '0; evt_clr = '0;
    drv_en = '0; drv_val = '0; filt_len = 4'd0;
    for (int i = 0; i < IOW; i++) portselnum[i] = PW'(i);
    model_reset();
    @(negedge clk);
    ticks(2);
    chk_v("reset_data", data_from_gpio, 36'h0_0000_0000);
    chk_v("reset_rise", rise_evt, 36'h0_0000_0000);
    reset = 1'b0;

    // Push-pull drive, one clock of latency.
    out_ena = '1; out_data = 36'h5_A5A5_A5A5;
    tick();
    chk_v("drive_1clk", gpioport, 36'h5_A5A5_A5A5);
    ticks(3);
    chk_v("loopback", data_from_gpio, 36'h5_A5A5_A5A5);

    // Asynchronous reset clears the output mux immediately.
    #2 reset = 1'b1;
    #1 chk_v("async_reset_pins", gpioport, 36'h0_0000_0000);
    model_reset();
    @(negedge clk);
    tick();
    chk_v("async_reset_data", data_from_gpio, 36'h0_0000_0000);
    reset = 1'b0;
    ticks(4);

    // Open drain on pin 3.
    od[3] = 1'b1; out_data[3] = 1'b1;
    tick();
    chk_b("od_low", gpioport[3], 1'b0);
    ticks(4);
    out_data[3] = 1'b0;
    tick();
    chk_b("od_release", gpioport[3], 1'b1);
    ticks(2);
    chk_b("od_data_early", data_from_gpio[3], 1'b0);
    tick();
    chk_b("od_data_3clk", data_from_gpio[3], 1'b1);

    // Routing: channel 5 reads pin 12, then an out-of-range index.
    out_ena = '0; od = '0; drv_en[12] = 1'b1; drv_val[12] = 1'b0; portselnum[5] = 8'd12;
    ticks(4);
    drv_val[12] = 1'b1;
    ticks(2);
    chk_b("route_early", data_from_gpio[5], 1'b0);
    tick();
    chk_b("route_follow", data_from_gpio[5], 1'b1);
    portselnum[5] = 8'd40; out_ena[5] = 1'b1; out_data = '1;
    tick();
    chk_b("route_oor_outmux", gpioport[5], 1'b0);
    ticks(2);
    chk_b("route_oor_data", data_from_gpio[5], 1'b0);

    // Glitch filter on pin 0 with filt_len=4.
    for (int i = 0; i < IOW; i++) portselnum[i] = PW'(i);
    out_ena = '0; drv_en = '0; drv_en[0] = 1'b1; drv_val = '0; filt_len = 4'd4; evt_clr = '1;
    ticks(10);
    evt_clr = '0;
    ticks(2);
    seen = 1'b0;
    drv_val[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin tick(); seen |= data_from_gpio[0]; end
    drv_val[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin tick(); seen |= data_from_gpio[0]; end
    chk_b("filt_reject", seen, 1'b0);
    chk_b("filt_reject_evt", rise_evt[0], 1'b0);
    drv_val[0] = 1'b1;
    ticks(6);
    chk_b("filt_accept_early", data_from_gpio[0], 1'b0);
    tick();
    chk_b("filt_accept_7clk", data_from_gpio[0], 1'b1);

    // Events on pin 7 with filt_len=0.
    filt_len = 4'd0; drv_en[7] = 1'b1; drv_val[7] = 1'b0;
    ticks(5);
    evt_clr[7] = 1'b1; tick(); evt_clr[7] = 1'b0;
    drv_val[7] = 1'b1; ticks(4);
    drv_val[7] = 1'b0; ticks(4);
    chk_b("evt_rise_sticky", rise_evt[7], EVT);
    chk_b("evt_fall_sticky", fall_evt[7], EVT);
    drv_val[7] = 1'b1;
    ticks(2);
    evt_clr[7] = 1'b1; tick(); evt_clr[7] = 1'b0;
    chk_b("evt_set_wins", rise_evt[7], EVT);
    chk_b("evt_fall_clr", fall_evt[7], 1'b0);
    chk_b("evt_data", data_from_gpio[7], 1'b1);

    // Randomized traffic, filt_len changed between segments with counts in flight.
    for (int seg = 0; seg < 30; seg++) begin
      filt_len = (seg % 6 == 5) ? 4'($urandom_range(15, 0)) : lens[seg % 5];
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(15, 0) == 0) begin
          out_ena = rnd36(); od = rnd36();
          for (int k = 0; k < 3; k++) portselnum[$urandom_range(IOW-1, 0)] = PW'($urandom_range(47, 0));
        end
        out_data ^= rnd36() & rnd36() & rnd36();
        if (filt_len > 4'd4) drv_val ^= rnd36() & rnd36() & rnd36() & rnd36() & rnd36();
        else                 drv_val ^= rnd36() & rnd36() & rnd36();
        drv_en  = ~out_ena & ~rnd36() | ~out_ena & rnd36() & rnd36();
        evt_clr = rnd36() & rnd36() & rnd36() & rnd36();
        if ($urandom_range(199, 0) == 0) begin
          reset = 1'b1;
          model_reset();
        end
        tick();
        reset = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
